// File: rtl/dft_crm_pkg.sv
// Shared types for the CRM divided-clock monitor: FSM states and fault codes.
package dft_crm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_MEAS   = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_PER  = 2'b01;
  localparam logic [1:0] ERR_DUTY = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/dft_crm_edge_cnt.sv
// Rising-edge detect on the divided clock plus saturating period/high counters.
module dft_crm_edge_cnt #(
  parameter int DIV_PARAM = 3,
  parameter int CW        = $clog2(2*DIV_PARAM+2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          div_in,
  output logic          rise,
  output logic [CW-1:0] per_cnt,
  output logic [CW-1:0] hi_cnt
);

  localparam logic [CW-1:0] SAT = CW'(2*DIV_PARAM+1);

  logic div_d;

  assign rise = div_in & ~div_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_d   <= 1'b0;
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      div_d <= div_in;
      if (rise) begin
        per_cnt <= CW'(1);
        hi_cnt  <= CW'(1);
      end else begin
        // Saturate so a dead clock parks at SAT and the timeout stays asserted.
        if (per_cnt != SAT)          per_cnt <= per_cnt + CW'(1);
        if (div_in && hi_cnt != SAT) hi_cnt  <= hi_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dft_crm_div_mon.sv
// Divided-clock monitor: checks period/duty of div_in in clk cycles, tracks lock
// and reports period, duty and stuck-clock faults.
module dft_crm_div_mon
  import dft_crm_pkg::*;
#(
  parameter int DIV_PARAM  = 3,
  parameter int DUTY_CYCLE = 2,
  parameter int LOCK_CNT   = 4,
  parameter int CW         = $clog2(2*DIV_PARAM+2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          test_mode,
  input  logic          en,
  input  logic          div_in,
  input  logic          clr_err,
  output logic          lock,
  output logic          err,
  output logic          err_sticky,
  output logic [1:0]    err_code,
  output logic [CW-1:0] meas_period,
  output logic [CW-1:0] meas_high
);

  localparam int            GW     = $clog2(LOCK_CNT+1);
  localparam logic [CW-1:0] SAT    = CW'(2*DIV_PARAM+1);
  localparam logic [CW-1:0] DIV_V  = CW'(DIV_PARAM);
  localparam logic [CW-1:0] DUTY_V = CW'(DUTY_CYCLE);

  state_e        state;
  logic [GW-1:0] good_cnt;
  logic          rise;
  logic [CW-1:0] per_cnt, hi_cnt;

  dft_crm_edge_cnt #(.DIV_PARAM(DIV_PARAM), .CW(CW)) u_edge (
    .clk     (clk),
    .rst     (rst),
    .div_in  (div_in),
    .rise    (rise),
    .per_cnt (per_cnt),
    .hi_cnt  (hi_cnt)
  );

  logic active, per_bad, duty_bad, tmo;
  assign active   = (state == ST_MEAS) || (state == ST_LOCKED);
  assign per_bad  = per_cnt != DIV_V;
  assign duty_bad = hi_cnt != DUTY_V;
  assign tmo      = active && !rise && (per_cnt == SAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      good_cnt    <= '0;
      lock        <= 1'b0;
      err         <= 1'b0;
      err_sticky  <= 1'b0;
      err_code    <= ERR_NONE;
      meas_period <= '0;
      meas_high   <= '0;
    end else begin
      err <= 1'b0;
      // A fault later in this block overrides the clear.
      if (clr_err) err_sticky <= 1'b0;
      if (test_mode || !en) begin
        state    <= ST_IDLE;
        lock     <= 1'b0;
        good_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ACQ;
          ST_ACQ: if (rise) begin
            state    <= ST_MEAS;
            good_cnt <= '0;
          end
          ST_MEAS, ST_LOCKED: begin
            if (rise) begin
              meas_period <= per_cnt;
              meas_high   <= hi_cnt;
              if (!per_bad && !duty_bad) begin
                if (state == ST_MEAS) begin
                  good_cnt <= good_cnt + GW'(1);
                  if (good_cnt == GW'(LOCK_CNT-1)) begin
                    state <= ST_LOCKED;
                    lock  <= 1'b1;
                  end
                end
              end else begin
                state      <= ST_MEAS;
                good_cnt   <= '0;
                lock       <= 1'b0;
                err        <= 1'b1;
                err_sticky <= 1'b1;
                err_code   <= per_bad ? ERR_PER : ERR_DUTY;
              end
            end else if (tmo) begin
              state      <= ST_ACQ;
              good_cnt   <= '0;
              lock       <= 1'b0;
              err        <= 1'b1;
              err_sticky <= 1'b1;
              err_code   <= ERR_TMO;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dft_crm_div_mon.sv
// Scoreboard bench for dft_crm_div_mon (DIV_PARAM=3, DUTY_CYCLE=2, LOCK_CNT=4).
module tb_dft_crm_div_mon;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, test_mode, en, div_in, clr_err;
  logic          lock, err, err_sticky;
  logic [1:0]    err_code;
  logic [CW-1:0] meas_period, meas_high;

  dft_crm_div_mon #(.DIV_PARAM(3), .DUTY_CYCLE(2), .LOCK_CNT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .test_mode   (test_mode),
    .en          (en),
    .div_in      (div_in),
    .clr_err     (clr_err),
    .lock        (lock),
    .err         (err),
    .err_sticky  (err_sticky),
    .err_code    (err_code),
    .meas_period (meas_period),
    .meas_high   (meas_high)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] code;
    int         p;
    int         h;
  } ev_t;

  ev_t  err_q[$];
  ev_t  lock_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rc, dc;
  logic mon_on = 1'b0;
  logic lock_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Drive h high cycles then l low cycles; rc records the cycle of the rise.
  task automatic per(input int h, input int l, input logic clr);
    for (int i = 0; i < h + l; i++) begin
      @(negedge clk);
      div_in  = (i < h);
      clr_err = (i == 0) ? clr : 1'b0;
      if (i == 0) rc = cyc;
      dc = cyc;
    end
  endtask

  task automatic drv0(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      div_in  = 1'b0;
      clr_err = 1'b0;
      dc = cyc;
    end
  endtask

  // Expectations for the rise issued by the next per() call.
  task automatic exp_err(input logic [1:0] code, input int p, input int h);
    err_q.push_back('{cyc: dc + 2, code: code, p: p, h: h});
  endtask

  task automatic exp_lock(input logic v);
    lock_q.push_back('{cyc: dc + 2, code: {1'b0, v}, p: 3, h: 2});
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (err !== 1'b0) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL err_unexpected cyc=%0d err=%b code=%b", cyc, err, err_code);
        end else begin
          ev_t e;
          e = err_q.pop_front();
          if (e.cyc != cyc || err_code !== e.code || meas_period !== CW'(e.p) ||
              meas_high !== CW'(e.h)) begin
            errors++;
            $display("FAIL err_event got cyc=%0d code=%b per=%0d hi=%0d exp cyc=%0d code=%b per=%0d hi=%0d",
                     cyc, err_code, meas_period, meas_high, e.cyc, e.code, e.p, e.h);
          end
        end
      end
      if (lock !== lock_prev) begin
        checks++;
        if (lock_q.size() == 0) begin
          errors++;
          $display("FAIL lock_unexpected cyc=%0d lock=%b", cyc, lock);
        end else begin
          ev_t e;
          e = lock_q.pop_front();
          if (e.cyc != cyc || lock !== e.code[0] ||
              (e.code[0] && (meas_period !== CW'(e.p) || meas_high !== CW'(e.h)))) begin
            errors++;
            $display("FAIL lock_event got cyc=%0d lock=%b per=%0d hi=%0d exp cyc=%0d lock=%b",
                     cyc, lock, meas_period, meas_high, e.cyc, e.code[0]);
          end
        end
      end
      lock_prev = lock;
    end
  end

  task automatic relock();
    per(2, 1, 1'b0); per(2, 1, 1'b0); per(2, 1, 1'b0);
    exp_lock(1'b1);
    per(2, 1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; test_mode = 1'b0; en = 1'b1; div_in = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_lock", lock, 0);
    chk("rst_err", err, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_code", err_code, 0);
    chk("rst_meas_period", meas_period, 0);
    chk("rst_meas_high", meas_high, 0);
    mon_on = 1'b1;
    rst = 1'b0;
    drv0(3);

    // 1: acquire and lock on 1,1,0 (lock 13 cycles after the first rise)
    per(2, 1, 1'b0);
    relock();
    per(2, 1, 1'b0);

    // 2: one stretched period -> period fault, then relock
    per(2, 2, 1'b0);
    exp_err(2'b01, 4, 2); exp_lock(1'b0);
    per(2, 1, 1'b0);
    relock();

    // 3: duty fault on 1,0,0, then relock
    per(1, 2, 1'b0);
    exp_err(2'b10, 3, 1); exp_lock(1'b0);
    per(2, 1, 1'b0);
    relock();

    // 4: stuck low -> timeout 8 cycles after the last rise, back to ACQ
    per(2, 1, 1'b0);
    err_q.push_back('{cyc: rc + 8, code: 2'b11, p: 3, h: 2});
    lock_q.push_back('{cyc: rc + 8, code: 2'b00, p: 3, h: 2});
    drv0(10);
    per(2, 1, 1'b0);
    relock();

    // 5: scan mode drops lock without faults; reset mid-lock clears everything
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      test_mode = 1'b1;
      div_in = 1'($urandom_range(0, 1));
      if (i == 0) lock_q.push_back('{cyc: cyc + 1, code: 2'b00, p: 3, h: 2});
    end
    @(negedge clk);
    test_mode = 1'b0; div_in = 1'b0;
    drv0(2);
    per(2, 1, 1'b0);
    relock();
    @(negedge clk);
    rst = 1'b1;
    lock_q.push_back('{cyc: cyc + 1, code: 2'b00, p: 3, h: 2});
    @(negedge clk);
    chk("midrst_lock", lock, 0);
    chk("midrst_err", err, 0);
    chk("midrst_sticky", err_sticky, 0);
    chk("midrst_code", err_code, 0);
    chk("midrst_meas_period", meas_period, 0);
    chk("midrst_meas_high", meas_high, 0);
    rst = 1'b0;
    drv0(3);

    // 6: clear colliding with a new fault keeps sticky; a lone clear drops it
    per(2, 1, 1'b0);
    per(2, 2, 1'b0);
    exp_err(2'b01, 4, 2);
    per(2, 1, 1'b0);
    chk("sticky_set", err_sticky, 1);
    per(2, 2, 1'b0);
    exp_err(2'b01, 4, 2);
    per(2, 1, 1'b1);
    chk("sticky_clr_vs_fault", err_sticky, 1);
    per(2, 1, 1'b1);
    chk("sticky_cleared", err_sticky, 0);
    chk("code_kept", err_code, 2'b01);

    @(negedge clk);
    en = 1'b0;
    drv0(12);
    chk("err_q_drained", err_q.size(), 0);
    chk("lock_q_drained", lock_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
